// File: rtl/hpu_seq.sv
// HPU job sequencer: item-memory write phase, datapath run phase, sticky done/err status.
// Optional run-phase cycle counter enabled with `define HPU_SEQ_PERF_EN.
module hpu_seq #(
  parameter int ITEM_W = 16,
  parameter int IDX_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [IDX_W-1:0]  cfg_addr_i,
  input  logic [IDX_W-1:0]  cfg_addr_j,
  input  logic              cfg_skip_matw,
  input  logic              dst_hs_last,
  output logic              matw,
  output logic [ITEM_W-1:0] mat_a,
  output logic              run,
  output logic [IDX_W-1:0]  addr_i,
  output logic [IDX_W-1:0]  addr_j,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       perf_cycles
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ITEM_W-1:0] mat_a_q, mat_a_d;
  logic [ITEM_W-1:0] item_num_q, item_num_d;
  logic [IDX_W-1:0]  addr_i_q, addr_i_d;
  logic [IDX_W-1:0]  addr_j_q, addr_j_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d    = state_q;
    mat_a_d    = '0;
    item_num_d = item_num_q;
    addr_i_d   = addr_i_q;
    addr_j_d   = addr_j_q;
    done_d     = done_q;
    err_d      = err_q;
    if (abort) begin
      // abort outranks start and dst_hs_last; latched config survives
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_addr_j > cfg_addr_i) begin
              err_d = 1'b1;
            end else begin
              item_num_d = cfg_item_num;
              addr_i_d   = cfg_addr_i;
              addr_j_d   = cfg_addr_j;
              done_d     = 1'b0;
              err_d      = 1'b0;
              state_d    = cfg_skip_matw ? RUN : LOAD;
            end
          end
        end
        LOAD: begin
          // compare before increment so an all-ones item_num never wraps
          if (mat_a_q == item_num_q) state_d = RUN;
          else                       mat_a_d = mat_a_q + ITEM_W'(1);
        end
        RUN: begin
          if (dst_hs_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mat_a_q    <= '0;
      item_num_q <= '0;
      addr_i_q   <= '0;
      addr_j_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mat_a_q    <= mat_a_d;
      item_num_q <= item_num_d;
      addr_i_q   <= addr_i_d;
      addr_j_q   <= addr_j_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign matw   = (state_q == LOAD);
  assign run    = (state_q == RUN);
  assign busy   = (state_q != IDLE);
  assign mat_a  = mat_a_q;
  assign addr_i = addr_i_q;
  assign addr_j = addr_j_q;
  assign done   = done_q;
  assign err    = err_q;

`ifdef HPU_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == RUN)      perf_d = perf_q + 32'd1;
    else if (state_d == RUN) perf_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_hpu_seq.sv
// Directed bench for hpu_seq: job-level reference model checked every cycle plus literal expectations.
module tb_hpu_seq;
  localparam int IW = 8;
  localparam int XW = 20;

  logic          clk;
  logic          rst, start, abort, skip, hs_last;
  logic [IW-1:0] cfg_item;
  logic [XW-1:0] cfg_ai, cfg_aj;
  logic          dut_matw, dut_run, dut_busy, dut_done, dut_err;
  logic [IW-1:0] dut_mat_a;
  logic [XW-1:0] dut_ai, dut_aj;
  logic [31:0]   dut_perf;

  int checks = 0;
  int failures = 0;

  hpu_seq #(.ITEM_W(IW), .IDX_W(XW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_item_num(cfg_item), .cfg_addr_i(cfg_ai), .cfg_addr_j(cfg_aj),
    .cfg_skip_matw(skip), .dst_hs_last(hs_last),
    .matw(dut_matw), .mat_a(dut_mat_a), .run(dut_run),
    .addr_i(dut_ai), .addr_j(dut_aj), .busy(dut_busy),
    .done(dut_done), .err(dut_err), .perf_cycles(dut_perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: phase of the current job, words written so far, latched config, status.
  localparam int P_IDLE = 0, P_WRITE = 1, P_EXEC = 2, P_FIN = 3;
  int          m_phase, m_words, m_item, m_perf;
  logic [XW-1:0] m_ai, m_aj;
  bit          m_done, m_err, m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE; m_words = 0; m_item = 0; m_perf = 0;
      m_ai = '0; m_aj = '0; m_done = 0; m_err = 0;
    end else begin
      if (m_phase == P_EXEC) m_perf++;
      if (abort) begin
        m_phase = P_IDLE; m_words = 0; m_done = 0;
      end else if (m_phase == P_IDLE) begin
        if (start && cfg_aj > cfg_ai) m_err = 1;
        else if (start) begin
          m_item = int'(cfg_item); m_ai = cfg_ai; m_aj = cfg_aj;
          m_done = 0; m_err = 0; m_words = 0;
          m_phase = skip ? P_EXEC : P_WRITE;
          if (skip) m_perf = 0;
        end
      end else if (m_phase == P_WRITE) begin
        m_words++;
        if (m_words == m_item + 1) begin
          m_phase = P_EXEC; m_words = 0; m_perf = 0;
        end
      end else if (m_phase == P_EXEC) begin
        if (hs_last) begin m_phase = P_FIN; m_done = 1; end
      end else begin
        m_phase = P_IDLE;
      end
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("matw",   32'(dut_matw), 32'(m_phase == P_WRITE));
      chk("mat_a",  32'(dut_mat_a), 32'(m_phase == P_WRITE ? m_words : 0));
      chk("run",    32'(dut_run),  32'(m_phase == P_EXEC));
      chk("busy",   32'(dut_busy), 32'(m_phase != P_IDLE));
      chk("done",   32'(dut_done), 32'(m_done));
      chk("err",    32'(dut_err),  32'(m_err));
      chk("addr_i", 32'(dut_ai),   32'(m_ai));
      chk("addr_j", 32'(dut_aj),   32'(m_aj));
`ifdef HPU_SEQ_PERF_EN
      chk("perf",   dut_perf, 32'(m_perf));
`else
      chk("perf",   dut_perf, 32'd0);
`endif
      chk("matw_run_excl", 32'(dut_matw & dut_run), 32'd0);
    end
  end

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic set_cfg(input int item, input int ai, input int aj, input bit sk);
    cfg_item = IW'(item); cfg_ai = XW'(ai); cfg_aj = XW'(aj); skip = sk;
  endtask

  // Counts write cycles until run rises; injects ignored start/hs_last pulses mid-write.
  task automatic count_writes(output int words, output int last_a);
    int n = 0;
    words = 0; last_a = -1;
    while (!dut_run && n < 400) begin
      if (dut_matw) begin words++; last_a = int'(dut_mat_a); end
      start   = (words == 10);
      hs_last = (words == 20);
      @(negedge clk); n++;
    end
    start = 1'b0; hs_last = 1'b0;
    if (n >= 400) chk("run_timeout", 32'(n), 32'd0);
  endtask

  int wr, la, n;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; hs_last = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(dut_busy), 32'd0);
    chk("rst_mat_a", 32'(dut_mat_a), 32'd0);
    chk("rst_perf", dut_perf, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100-word load, then a 25-cycle run
    set_cfg(99, 7, 2, 0);
    pulse_start();
    set_cfg(50, 11, 5, 0);
    count_writes(wr, la);
    chk("A_writes", 32'(wr), 32'd100);
    chk("A_last_a", 32'(la), 32'd99);
    pulse_start();
    repeat (23) @(negedge clk);
    hs_last = 1'b1; @(negedge clk); hs_last = 1'b0;
    chk("A_done", 32'(dut_done), 32'd1);
    chk("A_run_in_done", 32'(dut_run), 32'd0);
`ifdef HPU_SEQ_PERF_EN
    chk("A_perf", dut_perf, 32'd25);
`else
    chk("A_perf", dut_perf, 32'd0);
`endif
    @(negedge clk);
    chk("A_busy_after", 32'(dut_busy), 32'd0);
    chk("A_done_sticky", 32'(dut_done), 32'd1);
    chk("A_addr_i", 32'(dut_ai), 32'd7);
    chk("A_addr_j", 32'(dut_aj), 32'd2);

    // skip load; addr_j == addr_i is legal
    set_cfg(5, 3, 3, 1);
    pulse_start();
    chk("B_run_now", 32'(dut_run), 32'd1);
    chk("B_no_matw", 32'(dut_matw), 32'd0);
    set_cfg(5, 1, 9, 0);
    pulse_start();
    chk("B_err_ignored", 32'(dut_err), 32'd0);
    hs_last = 1'b1; @(negedge clk); hs_last = 1'b0;
    @(negedge clk);

    // rejected config
    set_cfg(5, 7, 8, 0);
    pulse_start();
    chk("C_err", 32'(dut_err), 32'd1);
    chk("C_busy", 32'(dut_busy), 32'd0);
    chk("C_addr_i", 32'(dut_ai), 32'd3);
    chk("C_addr_j", 32'(dut_aj), 32'd3);

    // abort mid-load at mat_a = 40
    set_cfg(99, 7, 2, 0);
    pulse_start();
    n = 0;
    while (!(dut_matw && dut_mat_a == IW'(40)) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("D_timeout", 32'(n), 32'd0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("D_matw", 32'(dut_matw), 32'd0);
    chk("D_mat_a", 32'(dut_mat_a), 32'd0);
    chk("D_busy", 32'(dut_busy), 32'd0);
    chk("D_addr_i_kept", 32'(dut_ai), 32'd7);

    // abort and hs_last together in RUN
    set_cfg(5, 4, 1, 1);
    pulse_start();
    repeat (2) @(negedge clk);
    abort = 1'b1; hs_last = 1'b1; @(negedge clk); abort = 1'b0; hs_last = 1'b0;
    chk("E_done", 32'(dut_done), 32'd0);
    chk("E_busy", 32'(dut_busy), 32'd0);

    // abort and start together in IDLE
    set_cfg(5, 6, 6, 1);
    abort = 1'b1; start = 1'b1; @(negedge clk); abort = 1'b0; start = 1'b0;
    chk("F_busy", 32'(dut_busy), 32'd0);
    chk("F_addr_i", 32'(dut_ai), 32'd4);

    // single-word load
    set_cfg(0, 2, 0, 0);
    pulse_start();
    count_writes(wr, la);
    chk("G_writes", 32'(wr), 32'd1);
    hs_last = 1'b1; @(negedge clk); hs_last = 1'b0;
    @(negedge clk);

    // all-ones item_num: full address range, no wrap
    set_cfg(255, 9, 9, 0);
    pulse_start();
    count_writes(wr, la);
    chk("H_writes", 32'(wr), 32'd256);
    chk("H_last_a", 32'(la), 32'd255);

    // rst outranks everything else
    rst = 1'b1; start = 1'b1; abort = 1'b1; hs_last = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0; hs_last = 1'b0;
    chk("R_busy", 32'(dut_busy), 32'd0);
    chk("R_addr_i", 32'(dut_ai), 32'd0);
    chk("R_done", 32'(dut_done), 32'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
